// File: rtl/bullet_pool.sv
// Multi-slot player projectile engine: per-slot bullet state updated once per frame,
// with fire cooldown, collision kills, bounding-box outputs and a registered pixel overlay.
module bullet_pool #(
  parameter int          NUM_BULLETS     = 4,
  parameter int          HRES            = 640,
  parameter int          VRES            = 480,
  parameter int          BULLET_W        = 4,
  parameter int          BULLET_H        = 12,
  parameter int          BULLET_SPEED    = 8,
  parameter int          SPAWN_Y         = 400,
  parameter int          COOLDOWN_FRAMES = 8,
  parameter logic [23:0] COLOR           = 24'hFFFF00
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    fsync,
  input  logic                    fire,
  input  logic signed [11:0]      player_x,
  input  logic [NUM_BULLETS-1:0]  hit,
  input  logic signed [11:0]      hpos,
  input  logic signed [11:0]      vpos,
  output logic [7:0]              pixel [0:2],
  output logic [NUM_BULLETS-1:0]  bullet_active,
  output logic signed [11:0]      bullet_left   [NUM_BULLETS],
  output logic signed [11:0]      bullet_right  [NUM_BULLETS],
  output logic signed [11:0]      bullet_top    [NUM_BULLETS],
  output logic signed [11:0]      bullet_bottom [NUM_BULLETS],
  output logic                    fire_ack
);

  localparam int                 CD_W     = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic signed [11:0] SPEED_S  = 12'(BULLET_SPEED);
  localparam logic signed [11:0] SPAWN_S  = 12'(SPAWN_Y);
  localparam logic signed [11:0] W_M1     = 12'(BULLET_W - 1);
  localparam logic signed [11:0] H_M1     = 12'(BULLET_H - 1);
  localparam logic signed [12:0] HALF_W   = 13'(BULLET_W / 2);
  localparam logic signed [12:0] MAX_LEFT = 13'(HRES - BULLET_W);
  localparam logic [CD_W-1:0]    CD_LOAD  = CD_W'(COOLDOWN_FRAMES - 1);

  // Widened to 13 bits so a very negative player_x cannot wrap before the clamp.
  function automatic logic signed [11:0] clamp_left(input logic signed [11:0] x);
    logic signed [12:0] l;
    l = {x[11], x} - HALF_W;
    if (l < 13'sd0)
      clamp_left = 12'sd0;
    else if (l > MAX_LEFT)
      clamp_left = MAX_LEFT[11:0];
    else
      clamp_left = l[11:0];
  endfunction

  logic [NUM_BULLETS-1:0] active_p0;
  logic signed [11:0]     left_p0 [NUM_BULLETS];
  logic signed [11:0]     top_p0  [NUM_BULLETS];
  logic                   fire_pend_p0;
  logic [NUM_BULLETS-1:0] hit_pend_p0;
  logic [CD_W-1:0]        cooldown_p0;
  logic                   fire_ack_p0;
  logic                   pix_on_p1;

  logic [NUM_BULLETS-1:0] act_n;
  logic signed [11:0]     left_n [NUM_BULLETS];
  logic signed [11:0]     top_n  [NUM_BULLETS];
  logic [CD_W-1:0]        cd_n;
  logic                   spawn;
  logic                   pix_hit;

  // Frame update: kills and motion first, so a slot freed this frame can take the spawn.
  always_comb begin
    act_n = active_p0;
    cd_n  = cooldown_p0;
    spawn = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      left_n[i] = left_p0[i];
      top_n[i]  = top_p0[i];
      if (active_p0[i]) begin
        if (hit_pend_p0[i] || hit[i])
          act_n[i] = 1'b0;
        else if (top_p0[i] < SPEED_S)
          act_n[i] = 1'b0;
        else
          top_n[i] = top_p0[i] - SPEED_S;
      end
    end
    if (cooldown_p0 != '0)
      cd_n = cooldown_p0 - 1'b1;
    if ((fire_pend_p0 || fire) && (cooldown_p0 == '0)) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (!spawn && !act_n[i]) begin
          spawn     = 1'b1;
          act_n[i]  = 1'b1;
          left_n[i] = clamp_left(player_x);
          top_n[i]  = SPAWN_S;
        end
      end
    end
    if (spawn)
      cd_n = CD_LOAD;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      active_p0    <= '0;
      fire_pend_p0 <= 1'b0;
      hit_pend_p0  <= '0;
      cooldown_p0  <= '0;
      fire_ack_p0  <= 1'b0;
      pix_on_p1    <= 1'b0;
    end else begin
      pix_on_p1 <= pix_hit;
      if (fsync) begin
        active_p0    <= act_n;
        cooldown_p0  <= cd_n;
        fire_ack_p0  <= spawn;
        fire_pend_p0 <= 1'b0;
        hit_pend_p0  <= '0;
      end else begin
        fire_ack_p0 <= 1'b0;
        if (fire)
          fire_pend_p0 <= 1'b1;
        hit_pend_p0 <= hit_pend_p0 | (hit & active_p0);
      end
    end
  end

  // Position registers are only meaningful while the matching active bit is set.
  always_ff @(posedge pixel_clk) begin
    if (fsync) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        left_p0[i] <= left_n[i];
        top_p0[i]  <= top_n[i];
      end
    end
  end

  always_comb begin
    pix_hit = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (active_p0[i]) begin
        bullet_left[i]   = left_p0[i];
        bullet_right[i]  = left_p0[i] + W_M1;
        bullet_top[i]    = top_p0[i];
        bullet_bottom[i] = top_p0[i] + H_M1;
      end else begin
        bullet_left[i]   = 12'sd0;
        bullet_right[i]  = 12'sd0;
        bullet_top[i]    = 12'sd0;
        bullet_bottom[i] = 12'sd0;
      end
      if (active_p0[i] && hpos >= bullet_left[i] && hpos <= bullet_right[i] &&
          vpos >= bullet_top[i] && vpos <= bullet_bottom[i])
        pix_hit = 1'b1;
    end
  end

  // Pixel stage: one cycle behind hpos/vpos.
  assign pixel[0]      = pix_on_p1 ? COLOR[23:16] : 8'h00;
  assign pixel[1]      = pix_on_p1 ? COLOR[15:8]  : 8'h00;
  assign pixel[2]      = pix_on_p1 ? COLOR[7:0]   : 8'h00;
  assign bullet_active = active_p0;
  assign fire_ack      = fire_ack_p0;

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: directed scenarios with literal expectations plus a random phase,
// all cross-checked every cycle against a frame-level behavioural model.
module tb_bullet_pool;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, fsync = 1'b0, fire = 1'b0;
  logic signed [11:0] player_x = '0, hpos = '0, vpos = '0;
  logic [N-1:0] hit = '0;
  logic [7:0] pixel [0:2];
  logic [N-1:0] bullet_active;
  logic signed [11:0] bl [N], br [N], bt [N], bb [N];
  logic fire_ack;

  bullet_pool dut (
    .pixel_clk(clk), .rst(rst), .fsync(fsync), .fire(fire), .player_x(player_x),
    .hit(hit), .hpos(hpos), .vpos(vpos), .pixel(pixel), .bullet_active(bullet_active),
    .bullet_left(bl), .bullet_right(br), .bullet_top(bt), .bullet_bottom(bb),
    .fire_ack(fire_ack)
  );

  int errors = 0, checks = 0;
  bit chk_en = 0;

  // Behavioural model: one record per slot, updated per frame from the rules.
  bit m_act [N];
  int m_left [N], m_top [N];
  bit m_hp [N];
  bit m_fp, m_ack, m_pix;
  int m_cd;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_hp[i] = 0; end
      m_fp = 0; m_ack = 0; m_pix = 0; m_cd = 0;
    end else begin
      int h, v, px, lft;
      bit ok, fe, done;
      h = hpos; v = vpos; px = player_x;
      m_pix = 0;
      for (int i = 0; i < N; i++)
        if (m_act[i] && h >= m_left[i] && h < m_left[i] + 4 && v >= m_top[i] && v < m_top[i] + 12)
          m_pix = 1;
      if (fsync) begin
        for (int i = 0; i < N; i++) begin
          if (m_act[i]) begin
            if (m_hp[i] || hit[i]) m_act[i] = 0;
            else if (m_top[i] < 8) m_act[i] = 0;
            else m_top[i] -= 8;
          end
        end
        ok = (m_cd == 0);
        if (m_cd > 0) m_cd--;
        fe = m_fp || fire;
        done = 0;
        if (fe && ok) begin
          lft = px - 2;
          if (lft < 0) lft = 0;
          if (lft > 636) lft = 636;
          for (int i = 0; i < N; i++)
            if (!done && !m_act[i]) begin
              done = 1; m_act[i] = 1; m_left[i] = lft; m_top[i] = 400;
            end
        end
        if (done) m_cd = 7;
        m_ack = done;
        m_fp = 0;
        for (int i = 0; i < N; i++) m_hp[i] = 0;
      end else begin
        m_ack = 0;
        if (fire) m_fp = 1;
        for (int i = 0; i < N; i++) if (hit[i] && m_act[i]) m_hp[i] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int ea;
      ea = 0;
      for (int i = 0; i < N; i++) if (m_act[i]) ea |= (1 << i);
      check("model_active", bullet_active, ea);
      for (int i = 0; i < N; i++) begin
        check($sformatf("model_left%0d", i),   bl[i], m_act[i] ? m_left[i] : 0);
        check($sformatf("model_right%0d", i),  br[i], m_act[i] ? m_left[i] + 3 : 0);
        check($sformatf("model_top%0d", i),    bt[i], m_act[i] ? m_top[i] : 0);
        check($sformatf("model_bottom%0d", i), bb[i], m_act[i] ? m_top[i] + 11 : 0);
      end
      check("model_ack", fire_ack, m_ack);
      check("model_pixel", {pixel[0], pixel[1], pixel[2]}, m_pix ? 24'hFFFF00 : 0);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic frame();
    fsync = 1; tick(); fsync = 0; tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    // Reset state
    repeat (5) tick();
    chk_en = 1;
    rst = 0;
    check("rst_active", bullet_active, 0);
    check("rst_pixel", {pixel[0], pixel[1], pixel[2]}, 0);
    check("rst_ack", fire_ack, 0);
    repeat (3) frame();
    check("idle_active", bullet_active, 0);
    check("idle_left0", bl[0], 0);
    check("idle_bottom3", bb[3], 0);

    // Single shot
    player_x = 320; fire = 1; tick(); fire = 0;
    fsync = 1; tick();
    check("shot_active", bullet_active, 1);
    check("shot_L", bl[0], 318);
    check("shot_R", br[0], 321);
    check("shot_T", bt[0], 400);
    check("shot_B", bb[0], 411);
    check("shot_ack", fire_ack, 1);
    fsync = 0; tick();
    check("shot_ack_low", fire_ack, 0);
    repeat (10) frame();
    check("shot_T10", bt[0], 320);
    hpos = 319; vpos = 325; tick();
    check("shot_pixel", {pixel[0], pixel[1], pixel[2]}, 24'hFFFF00);
    hpos = 0; vpos = 0; tick();
    check("shot_pixel_off", {pixel[0], pixel[1], pixel[2]}, 0);

    // Right clamp, with fire and fsync in the same cycle
    do_reset();
    player_x = 639; fire = 1; fsync = 1; tick(); fire = 0; fsync = 0;
    check("clampR_ack", fire_ack, 1);
    check("clampR_L", bl[0], 636);
    check("clampR_R", br[0], 639);
    tick();

    // Left clamp and lifetime
    do_reset();
    player_x = -5; fire = 1; fsync = 1; tick(); fire = 0; fsync = 0;
    check("clampL_L", bl[0], 0);
    check("clampL_R", br[0], 3);
    tick();
    repeat (50) frame();
    check("life50_active", bullet_active, 1);
    check("life50_top", bt[0], 0);
    frame();
    check("life51_active", bullet_active, 0);

    // Cooldown and full pool with fire held
    do_reset();
    player_x = 100; fire = 1;
    for (int k = 0; k <= 51; k++) begin
      fsync = 1; tick();
      check($sformatf("hold_ack_f%0d", k), fire_ack,
            (k == 0 || k == 8 || k == 16 || k == 24 || k == 51) ? 1 : 0);
      if (k == 24 || k == 48 || k == 51) check($sformatf("hold_active_f%0d", k), bullet_active, 15);
      fsync = 0; tick();
    end
    check("hold_respawn_T", bt[0], 400);
    fire = 0;

    // Hit kill
    do_reset();
    player_x = 200; fire = 1; fsync = 1; tick(); fire = 0; fsync = 0; tick();
    repeat (7) frame();
    fire = 1; fsync = 1; tick(); fire = 0; fsync = 0; tick();
    check("hit_pre_active", bullet_active, 3);
    hit = 4'b0010; tick(); hit = 0; tick();
    check("hit_midframe_active", bullet_active, 3);
    hit = 4'b0100; tick(); hit = 0; tick();
    fsync = 1; tick(); fsync = 0;
    check("hit_post_active", bullet_active, 1);
    check("hit_box1_L", bl[1], 0);
    check("hit_box1_B", bb[1], 0);
    check("hit_slot0_T", bt[0], 328);
    tick();

    // Reset mid-flight, coincident with fsync
    do_reset();
    player_x = 100; fire = 1;
    repeat (17) frame();
    fire = 0;
    check("mid_active", bullet_active, 7);
    hpos = 99; vpos = 275; tick();
    check("mid_pixel_on", {pixel[0], pixel[1], pixel[2]}, 24'hFFFF00);
    rst = 1; fsync = 1; tick(); rst = 0; fsync = 0;
    check("mid_rst_active", bullet_active, 0);
    check("mid_rst_pixel", {pixel[0], pixel[1], pixel[2]}, 0);
    check("mid_rst_L0", bl[0], 0);
    check("mid_rst_ack", fire_ack, 0);
    fire = 1; fsync = 1; tick(); fire = 0; fsync = 0;
    check("mid_refire_ack", fire_ack, 1);
    check("mid_refire_active", bullet_active, 1);
    tick();

    // Random phase
    for (int c = 0; c < 2000; c++) begin
      int t;
      rst   = ($urandom % 300) == 0;
      fsync = ($urandom % 3) == 0;
      fire  = ($urandom % 4) == 0;
      hit   = (($urandom % 10) == 0) ? N'($urandom) : '0;
      t = int'($urandom_range(0, 700)) - 30;
      player_x = 12'(t);
      t = t + int'($urandom_range(0, 12)) - 6;
      hpos = 12'(t);
      vpos = 12'($urandom_range(0, 479));
      tick();
    end
    rst = 0; fsync = 0; fire = 0; hit = '0;
    tick(); tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bullet_pool.md
# bullet_pool

Multi-slot player projectile engine: the parametrised successor to the single-bullet block. It manages `NUM_BULLETS` independent bullets with a frame-based fire cooldown, collision kill inputs and per-slot bounding boxes. It sits between player input/position logic, the collision checker and the pixel mixer, all in the `pixel_clk` domain. Screen constants default to the values in `params`.

## Interface
- `NUM_BULLETS`, 4: slot count, 1..8.
- `HRES`, 640: horizontal resolution.
- `VRES`, 480: vertical resolution.
- `BULLET_W`, 4: bullet width in pixels.
- `BULLET_H`, 12: bullet height in pixels.
- `BULLET_SPEED`, 8: upward pixels moved per frame, ≥1.
- `SPAWN_Y`, 400: `top` of a freshly spawned bullet; requires `SPAWN_Y + BULLET_H ≤ VRES`.
- `COOLDOWN_FRAMES`, 8: minimum fsync count between spawns, ≥1.
- `COLOR`, 24'hFFFF00: RGB drawn for any bullet pixel.
- `pixel_clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fsync`  in  1  one-cycle frame-start pulse.
- `fire`  in  1  fire request, level or pulse, sampled every cycle.
- `player_x`  in  s12  player centre x.
- `hit`  in  NUM_BULLETS  per-slot collision kill, sampled every cycle.
- `hpos`, `vpos`  in  s12 each  current raster position.
- `pixel[0:2]`  out  3×8  R, G, B.
- `bullet_active`  out  NUM_BULLETS  slot-valid bitmap.
- `bullet_left/right/top/bottom[NUM_BULLETS]`  out  s12 each  per-slot bounding box.
- `fire_ack`  out  1  one-cycle pulse when a spawn occurs.

## Operation
- **Sticky latches, set on any cycle.**
  - `fire_pending` is set when `fire=1`.
  - `hit_pending[i]` is set when `hit[i]=1` and slot i is active.
  - A `hit` on an inactive slot is ignored.
  - A `fire` or `hit` that is high in the fsync cycle itself counts for that frame.
- **Frame update, applied only on a cycle with `fsync=1`, in this order within one edge:**
  - Per active slot i:
    - If `hit_pending[i]`: deactivate.
    - Else if `top[i] < BULLET_SPEED`: deactivate (off-screen).
    - Else: `top[i] -= BULLET_SPEED`.
  - Cooldown: `spawn_ok = (cooldown == 0)`. If `cooldown > 0`, decrement it.
  - Spawn:
    - Condition: `(fire_pending | fire) & spawn_ok` and at least one slot is free after this frame's deactivations.
    - Use the lowest-index free slot. A slot freed this frame is reusable this frame.
    - `left = clamp(player_x − BULLET_W/2, 0, HRES − BULLET_W)`.
    - `top = SPAWN_Y`.
    - Load `cooldown = COOLDOWN_FRAMES − 1`.
    - Pulse `fire_ack`.
    - A newly spawned bullet does not move in its spawn frame.
  - Clear `fire_pending` and all `hit_pending` bits. A request blocked by cooldown or a full pool is dropped, not queued.
- **Bounding box.**
  - `right = left + BULLET_W − 1` and `bottom = top + BULLET_H − 1`, derived combinationally from the registered `left`/`top`.
  - For an inactive slot, all four box outputs are driven 0.
- **Arithmetic.** Performed in signed 12-bit. The clamp is evaluated on the signed value, so a negative `player_x` gives `left = 0`.
- **Pixel output.**
  - `pixel = COLOR` if any active slot satisfies `left ≤ hpos ≤ right && top ≤ vpos ≤ bottom`, otherwise 0.
  - Overlapping bullets produce the same colour; there is no priority issue.
- **Invariant.** An active bullet always satisfies `0 ≤ left`, `right < HRES`, `0 ≤ top` and `bottom < VRES`.

## Timing
- **Reset values.** `bullet_active = 0`, all box outputs 0, `pixel` all 0, `fire_ack = 0`, `cooldown = 0`, and all pending latches cleared.
  - Reset during flight kills every bullet on the next edge.
  - `rst` has priority over a coincident `fsync`, `fire` or `hit`.
- **Frame update latency.** State sampled at the fsync edge appears on `bullet_active` and the box outputs from the following cycle onward. The state is then stable until the next fsync.
- **`fire_ack`.** High for exactly the one cycle after the spawning fsync edge.
- **Pixel latency.** `pixel` is registered with 1-cycle latency from `hpos`/`vpos`.
- **Spawn rate.** With `fire` held, spawns occur at most every `COOLDOWN_FRAMES` fsyncs.
- **Lifetime.** A bullet lives `floor(SPAWN_Y / BULLET_SPEED) + 1` update frames. With defaults, `top` reaches 0 after 50 updates and the bullet deactivates on update 51.
- **Back-to-back fsync.** Consecutive-cycle fsync pulses are each a full frame update.

## Test plan
- **Reset state.** Hold `rst` for 5 cycles, then pulse `fsync` ×3 with no `fire` → `bullet_active = 0`, `pixel = 0`, all boxes 0.
- **Single shot.** `player_x = 320`, `fire` for 1 cycle, then `fsync` → slot 0 active with L=318, R=321, T=400, B=411, and `fire_ack` high for one cycle.
  - After 10 further fsyncs → T=320.
  - Raster at (319, 325) → `pixel = FF,FF,00` one cycle later.
- **Edge clamp and lifetime.**
  - `player_x = 639` → L=636, R=639.
  - `player_x = −5` → L=0.
  - Each bullet is active for exactly 51 frame updates after spawn, then `bullet_active[i] = 0`.
- **Cooldown and full pool.** Hold `fire` high with defaults.
  - Spawns in slots 0..3 at fsync 0, 8, 16, 24.
  - No spawn at 32, 40 or 48 (pool full).
  - At fsync 51, slot 0 deactivates and respawns in the same update (`fire_ack` asserted).
- **Hit kill.**
  - With slots 0 and 1 active, pulse `hit[1]` mid-frame → slot 1 is still active until the next fsync, then inactive with box 0. Slot 0 is unaffected.
  - `hit[2]` on an inactive slot → no effect.
- **Simultaneous events and reset mid-flight.**
  - `fire` and `fsync` in the same cycle → spawn on that edge.
  - `rst` in the same cycle as `fsync` with 3 bullets active → all outputs at reset values on the next cycle, and a following fire spawns in slot 0 without cooldown.
